// File: rtl/cmp_arb_pkg.sv
// Shared types and result encodings for the shared-comparator arbiter.
// The result word is {lt, gt, eq}; exactly one bit is set for a valid result.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    // Collapses raw comparator flags into the one-hot result encoding.
    function automatic logic [2:0] cmp_encode(input logic lt, input logic gt, input logic eq);
        logic [2:0] res;
        if (lt) begin
            res = CMP_LT;
        end else if (gt) begin
            res = CMP_GT;
        end else if (eq) begin
            res = CMP_EQ;
        end else begin
            res = CMP_EQ;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Purely combinational WIDTH-bit magnitude comparator, unsigned or two's complement.
module cmp_core #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    // Magnitude compare; signedness is fixed at elaboration.
    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        if (SIGNED_CMP) begin
            lt = ($signed(a) < $signed(b));
            gt = ($signed(a) > $signed(b));
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
        eq = (a == b);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters,
// returning a registered lt/gt/eq result tagged with the winner's index.
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       rsp_lt,
    output logic                       rsp_gt,
    output logic                       rsp_eq,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    state_t            state_r;
    state_t            state_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [2:0]        res_r;

    logic [ID_W-1:0]   win_s;
    logic              win_found_s;
    logic              hs_s;
    logic              accept_s;
    logic [WIDTH-1:0]  a_sel_s;
    logic [WIDTH-1:0]  b_sel_s;
    logic              core_lt_s;
    logic              core_gt_s;
    logic              core_eq_s;
    logic [ID_W-1:0]   next_ptr_s;

    // Round-robin search: scanning offsets high-to-low lets the smallest offset win.
    always_comb begin
        int idx;
        idx         = 0;
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (req_valid[idx]) begin
                win_s       = idx[ID_W-1:0];
                win_found_s = 1'b1;
            end else begin
                win_s       = win_s;
                win_found_s = win_found_s;
            end
        end
    end

    assign a_sel_s = req_a[int'(win_s)*WIDTH +: WIDTH];
    assign b_sel_s = req_b[int'(win_s)*WIDTH +: WIDTH];

    // Grant is offered only in IDLE and is forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_r == IDLE) && win_found_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_s  = state_r;
        hs_s     = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    hs_s    = 1'b1;
                    state_s = CMP;
                end else begin
                    state_s = IDLE;
                end
            end
            CMP: begin
                state_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    accept_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Explicit wrap so non-power-of-2 N_REQ never reaches N_REQ.
    always_comb begin
        if (id_r == ID_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = id_r + ID_W'(1);
        end
    end

    cmp_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a  (a_r),
        .b  (b_r),
        .lt (core_lt_s),
        .gt (core_gt_s),
        .eq (core_eq_s)
    );

    // State, operand capture, result register and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            res_r       <= 3'b000;
        end else begin
            state_r <= state_s;
            if (hs_s) begin
                a_r  <= a_sel_s;
                b_r  <= b_sel_s;
                id_r <= win_s;
            end else begin
                a_r  <= a_r;
                b_r  <= b_r;
                id_r <= id_r;
            end
            if (state_r == CMP) begin
                res_r       <= cmp_encode(core_lt_s, core_gt_s, core_eq_s);
                rsp_id_r    <= id_r;
                rsp_valid_r <= 1'b1;
            end else if (accept_s) begin
                rsp_valid_r <= 1'b0;
                rr_ptr_r    <= next_ptr_s;
            end else begin
                rsp_valid_r <= rsp_valid_r;
                rr_ptr_r    <= rr_ptr_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_lt    = res_r[2];
    assign rsp_gt    = res_r[1];
    assign rsp_eq    = res_r[0];
    assign busy      = (state_r != IDLE);

endmodule
